// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin picks a byte in IDLE, then
// sends start, 8 data bits (LSB first), optional even parity, and stop.
module uart_tx_arbiter (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [15:0] divisor,
  input  logic        parity_en,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        Tx,
  output logic        busy,
  output logic        grant_id,
  output logic        tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      r_state, w_stateNext;
  logic [15:0] r_cnt, w_cntNext, r_div;
  logic [2:0]  r_bitIdx, w_bitIdxNext;
  logic [7:0]  r_data;
  logic        r_parEn, r_favour1, r_grant, r_tx, w_txNext;
  logic        w_sel1, w_accept, w_bitEnd;

  // req1 wins only when req0 is idle or it is req1's turn; ready is held low during reset
  assign w_sel1     = req1_valid && (!req0_valid || r_favour1);
  assign w_accept   = (r_state == IDLE) && PRESETn && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_sel1;
  assign req1_ready = w_accept && w_sel1;

  assign w_bitEnd = (r_cnt == r_div - 16'd1);
  assign tx_done  = (r_state == STOP) && w_bitEnd;
  assign busy     = (r_state != IDLE);
  assign grant_id = r_grant;
  assign Tx       = r_tx;

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt + 16'd1;
    w_bitIdxNext = r_bitIdx;
    w_txNext     = 1'b1;
    case (r_state)
      IDLE: begin
        w_cntNext = 16'd0;
        if (w_accept) w_stateNext = START;
      end
      START: begin
        if (w_bitEnd) begin
          w_stateNext  = DATA;
          w_cntNext    = 16'd0;
          w_bitIdxNext = 3'd0;
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          w_cntNext = 16'd0;
          if (r_bitIdx == 3'd7) w_stateNext = r_parEn ? PARITY : STOP;
          else                  w_bitIdxNext = r_bitIdx + 3'd1;
        end
      end
      PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = STOP;
          w_cntNext   = 16'd0;
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          w_stateNext = IDLE;
          w_cntNext   = 16'd0;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    // Line level follows the state being entered so Tx is registered yet aligned with it
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = r_data[w_bitIdxNext];
      PARITY:  w_txNext = ^r_data;
      default: w_txNext = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_cnt     <= 16'd0;
      r_bitIdx  <= 3'd0;
      r_data    <= 8'd0;
      r_div     <= 16'd1;
      r_parEn   <= 1'b0;
      r_favour1 <= 1'b0;
      r_grant   <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_bitIdx <= w_bitIdxNext;
      r_tx     <= w_txNext;
      if (w_accept) begin
        r_data    <= w_sel1 ? req1_data : req0_data;
        r_div     <= (divisor == 16'd0) ? 16'd1 : divisor;
        r_parEn   <= parity_en;
        r_grant   <= w_sel1;
        r_favour1 <= !w_sel1;
      end
    end
  end

endmodule
